// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions: register addressing, controller states and
// the pipeline-stage tag reused by the EX/MEM/WB trackers.
package fwd_hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 4;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } pipe_tag_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bus between the ID stage and the hazard/forwarding controller.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import fwd_hazard_ctrl_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic              id_rs_used;
    logic [REG_AW-1:0] id_rt;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    logic              flush;
    logic              sel_a;
    logic              sel_b;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
               id_rd, id_rd_we, id_is_load, flush,
        input  sel_a, sel_b, stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
               id_rd, id_rd_we, id_is_load, flush,
        output sel_a, sel_b, stall, stall_count
    );

endinterface

// File: rtl/fwd_hazard_ctrl_hazard_match_cmp.sv
// Compares one decode source operand against the instruction currently in EX.
module hazard_match_cmp
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_used,
    input  logic              i_ex_valid,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_we,
    output logic              o_match_c
);

    // r0 is hardwired to zero, so a write to it is never a real producer
    assign o_match_c = i_id_valid & i_used & i_ex_valid & i_ex_we
                     & (i_ex_rd == i_src) & (i_ex_rd != REG_ZERO);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage forwarding select and load-use stall controller with a
// saturating stall-cycle counter for performance debug.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    fwd_hazard_ctrl_if.slave   bus
);

    localparam int unsigned BUB_W = 2;
    localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    pipe_tag_t        r_ex;
    state_e           r_state;
    state_e           w_state_nxt;
    logic [BUB_W-1:0] r_bub_cnt;
    logic [BUB_W-1:0] w_bub_nxt;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_match_a;
    logic             w_match_b;
    logic             w_hazard;
    logic             w_stall;

    hazard_match_cmp u_cmp_a (
        .i_id_valid (bus.id_valid),
        .i_src      (bus.id_rs),
        .i_used     (bus.id_rs_used),
        .i_ex_valid (r_ex.valid),
        .i_ex_rd    (r_ex.rd),
        .i_ex_we    (r_ex.we),
        .o_match_c  (w_match_a)
    );

    hazard_match_cmp u_cmp_b (
        .i_id_valid (bus.id_valid),
        .i_src      (bus.id_rt),
        .i_used     (bus.id_rt_used),
        .i_ex_valid (r_ex.valid),
        .i_ex_rd    (r_ex.rd),
        .i_ex_we    (r_ex.we),
        .o_match_c  (w_match_b)
    );

    assign w_hazard = (w_match_a | w_match_b) & r_ex.load;

    // The first bubble is issued from RUN; STALL covers the remaining LOAD_LAT-1
    always_comb begin
        w_state_nxt = r_state;
        w_bub_nxt   = r_bub_cnt;
        w_stall     = 1'b0;
        if (bus.flush) begin
            w_state_nxt = RUN;
            w_bub_nxt   = '0;
        end else begin
            case (r_state)
                RUN: begin
                    w_stall = w_hazard;
                    if (w_hazard && (LOAD_LAT > 1)) begin
                        w_state_nxt = STALL;
                        w_bub_nxt   = BUB_INIT;
                    end
                end
                STALL: begin
                    w_stall = 1'b1;
                    if (r_bub_cnt == '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_bub_nxt = r_bub_cnt - BUB_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_bub_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= RUN;
            r_bub_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bub_cnt <= w_bub_nxt;
        end
    end

    // EX tag advances with decode, or takes a bubble on stall/flush
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ex <= '0;
        end else if (!w_stall && !bus.flush) begin
            r_ex <= '{valid: bus.id_valid, rd: bus.id_rd,
                      we: bus.id_rd_we, load: bus.id_is_load};
        end else begin
            r_ex <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    // Selects are early: the downstream operand mux registers them
    assign bus.sel_a       = w_match_a & ~r_ex.load & ~w_stall & ~bus.flush;
    assign bus.sel_b       = w_match_b & ~r_ex.load & ~w_stall & ~bus.flush;
    assign bus.stall       = w_stall;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) driven in lockstep from vector tables, corner sequences and random traffic.
module tb_fwd_hazard_ctrl;

    logic CLK;
    logic RESET_N;

    fwd_hazard_ctrl_if #(.CNT_W(16)) bus1 ();
    fwd_hazard_ctrl_if #(.CNT_W(4))  bus3 ();

    fwd_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut1 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus1));
    fwd_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4))  dut3 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus3));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic       valid;
        logic [3:0] rs;
        logic       rs_used;
        logic [3:0] rt;
        logic       rt_used;
        logic [3:0] rd;
        logic       we;
        logic       ld;
        logic       fl;
    } in_t;

    typedef struct {
        in_t  in;
        logic sa;
        logic sb;
        logic st;
        int   cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state, index 0 = LOAD_LAT 1 instance, 1 = LOAD_LAT 3 instance
    int m_ex_v[2], m_ex_rd[2], m_ex_we[2], m_ex_ld[2], m_rem[2], m_cnt[2];
    int LL[2]   = '{1, 3};
    int CMAX[2] = '{65535, 15};

    vec_t vecs[16];

    function automatic in_t mk(bit v, int rs, bit ru, int rt, bit tu, int rd, bit we, bit ld, bit fl);
        in_t x;
        x.valid = v;   x.rs = 4'(rs); x.rs_used = ru;
        x.rt = 4'(rt); x.rt_used = tu;
        x.rd = 4'(rd); x.we = we; x.ld = ld; x.fl = fl;
        return x;
    endfunction

    function automatic vec_t mv(in_t in, bit sa, bit sb, bit st, int cnt);
        vec_t r;
        r.in = in; r.sa = sa; r.sb = sb; r.st = st; r.cnt = cnt;
        return r;
    endfunction

    task automatic apply(input in_t x);
        bus1.id_valid = x.valid; bus1.id_rs = x.rs; bus1.id_rs_used = x.rs_used;
        bus1.id_rt = x.rt; bus1.id_rt_used = x.rt_used; bus1.id_rd = x.rd;
        bus1.id_rd_we = x.we; bus1.id_is_load = x.ld; bus1.flush = x.fl;
        bus3.id_valid = x.valid; bus3.id_rs = x.rs; bus3.id_rs_used = x.rs_used;
        bus3.id_rt = x.rt; bus3.id_rt_used = x.rt_used; bus3.id_rd = x.rd;
        bus3.id_rd_we = x.we; bus3.id_is_load = x.ld; bus3.flush = x.fl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ex_v[d] = 0; m_ex_rd[d] = 0; m_ex_we[d] = 0; m_ex_ld[d] = 0;
            m_rem[d] = 0; m_cnt[d] = 0;
        end
    endtask

    // Hold reset across one edge, check the quiet outputs, release away from the edge
    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        RESET_N = 1'b0;
        tick();
        chk("rst_stall1", 32'(bus1.stall), 0);
        chk("rst_cnt3", 32'(bus3.stall_count), 0);
        RESET_N = 1'b1;
        model_reset();
    endtask

    initial begin
        in_t  cur;
        in_t  load_r4;
        in_t  use_r4;
        logic ma, mb, est, esa, esb;
        logic [31:0] a_sa, a_sb, a_st, a_cnt;

        RESET_N = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("por_sel_a", 32'(bus1.sel_a), 0);
        chk("por_sel_b", 32'(bus1.sel_b), 0);
        chk("por_stall", 32'(bus1.stall), 0);
        chk("por_cnt", 32'(bus1.stall_count), 0);
        tick();
        do_reset();

        // table vectors on the LOAD_LAT=1 instance, one decode slot per entry
        vecs[0]  = mv(mk(1, 1, 0, 2, 0, 3, 1, 0, 0), 0, 0, 0, 0); // add r3
        vecs[1]  = mv(mk(1, 3, 1, 5, 1, 6, 1, 0, 0), 1, 0, 0, 0); // sub rs=r3 rt=r5
        vecs[2]  = mv(mk(1, 6, 1, 0, 0, 4, 1, 1, 0), 1, 0, 0, 0); // load r4, rs=r6
        vecs[3]  = mv(mk(1, 2, 1, 4, 1, 7, 1, 0, 0), 0, 0, 1, 0); // use r4 -> stall
        vecs[4]  = mv(mk(1, 2, 1, 4, 1, 7, 1, 0, 0), 0, 0, 0, 1); // held, released
        vecs[5]  = mv(mk(1, 7, 1, 0, 0, 0, 1, 0, 0), 1, 0, 0, 1); // write r0, rs=r7
        vecs[6]  = mv(mk(1, 0, 1, 0, 1, 7, 1, 0, 0), 0, 0, 0, 1); // read r0 twice
        vecs[7]  = mv(mk(1, 7, 1, 7, 1, 8, 1, 0, 0), 1, 1, 0, 1); // double match r7
        vecs[8]  = mv(mk(1, 8, 1, 0, 0, 2, 1, 0, 1), 0, 0, 0, 1); // flush kills sel
        vecs[9]  = mv(mk(1, 8, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1); // EX is bubble
        vecs[10] = mv(mk(1, 0, 0, 0, 0, 5, 1, 1, 0), 0, 0, 0, 1); // load r5
        vecs[11] = mv(mk(1, 5, 1, 5, 1, 5, 0, 0, 1), 0, 0, 0, 1); // hazard + flush
        vecs[12] = mv(mk(1, 5, 1, 0, 0, 5, 0, 0, 0), 0, 0, 0, 1); // bubble, we=0 producer
        vecs[13] = mv(mk(1, 5, 1, 0, 0, 9, 1, 0, 0), 0, 0, 0, 1); // ex_we=0 no match
        vecs[14] = mv(mk(0, 9, 1, 0, 0, 9, 1, 0, 0), 0, 0, 0, 1); // id_valid=0
        vecs[15] = mv(mk(1, 9, 1, 0, 0, 1, 1, 0, 0), 0, 0, 0, 1); // ex_valid=0

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].in);
            #3;
            chk($sformatf("v%0d_sel_a", i), 32'(bus1.sel_a), 32'(vecs[i].sa));
            chk($sformatf("v%0d_sel_b", i), 32'(bus1.sel_b), 32'(vecs[i].sb));
            chk($sformatf("v%0d_stall", i), 32'(bus1.stall), 32'(vecs[i].st));
            chk($sformatf("v%0d_cnt", i), 32'(bus1.stall_count), 32'(vecs[i].cnt));
            tick();
        end

        load_r4 = mk(1, 0, 0, 0, 0, 4, 1, 1, 0);
        use_r4  = mk(1, 1, 0, 4, 1, 9, 1, 0, 0);

        // load-use: 1 bubble vs 3 bubbles
        do_reset();
        apply(load_r4);
        tick();
        apply(use_r4);
        for (int k = 0; k < 6; k++) begin
            #3;
            chk($sformatf("lu_k%0d_stall1", k), 32'(bus1.stall), (k == 0) ? 1 : 0);
            chk($sformatf("lu_k%0d_stall3", k), 32'(bus3.stall), (k < 3) ? 1 : 0);
            chk($sformatf("lu_k%0d_selb1", k), 32'(bus1.sel_b), 0);
            chk($sformatf("lu_k%0d_selb3", k), 32'(bus3.sel_b), 0);
            tick();
        end
        chk("lu_cnt1", 32'(bus1.stall_count), 1);
        chk("lu_cnt3", 32'(bus3.stall_count), 3);

        // flush during the second stall cycle
        do_reset();
        apply(load_r4);
        tick();
        apply(use_r4);
        #3;
        chk("fl_k0_stall3", 32'(bus3.stall), 1);
        tick();
        cur = use_r4;
        cur.fl = 1'b1;
        apply(cur);
        #3;
        chk("fl_k1_stall3", 32'(bus3.stall), 0);
        tick();
        apply(use_r4);
        #3;
        chk("fl_after_stall3", 32'(bus3.stall), 0);
        chk("fl_cnt3", 32'(bus3.stall_count), 1);
        tick();

        // reset asserted while in STALL
        do_reset();
        apply(load_r4);
        tick();
        apply(use_r4);
        tick();
        #2;
        chk("rms_pre_stall3", 32'(bus3.stall), 1);
        RESET_N = 1'b0;
        #1;
        chk("rms_stall3", 32'(bus3.stall), 0);
        chk("rms_sel_a3", 32'(bus3.sel_a), 0);
        chk("rms_sel_b3", 32'(bus3.sel_b), 0);
        chk("rms_cnt3", 32'(bus3.stall_count), 0);
        tick();
        RESET_N = 1'b1;
        apply(use_r4);
        #3;
        chk("rms_post_stall3", 32'(bus3.stall), 0);
        chk("rms_post_cnt3", 32'(bus3.stall_count), 0);
        tick();

        // saturation: 7 load-use pairs = 21 stalls on the 4-bit counter
        do_reset();
        for (int n = 0; n < 7; n++) begin
            apply(load_r4);
            tick();
            apply(use_r4);
            for (int k = 0; k < 4; k++) tick();
        end
        #3;
        chk("sat_cnt3", 32'(bus3.stall_count), 15);
        chk("sat_cnt1", 32'(bus1.stall_count), 7);
        tick();

        // random traffic against the reference model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            cur.valid   = ($urandom_range(0, 7) != 0);
            cur.rs      = 4'($urandom_range(0, 3));
            cur.rs_used = 1'($urandom_range(0, 1));
            cur.rt      = 4'($urandom_range(0, 3));
            cur.rt_used = 1'($urandom_range(0, 1));
            cur.rd      = 4'($urandom_range(0, 3));
            cur.we      = ($urandom_range(0, 3) != 0);
            cur.ld      = ($urandom_range(0, 2) == 0);
            cur.fl      = ($urandom_range(0, 7) == 0);
            apply(cur);
            #3;
            for (int d = 0; d < 2; d++) begin
                ma = cur.valid && cur.rs_used && (m_ex_v[d] != 0) && (m_ex_we[d] != 0)
                     && (m_ex_rd[d] == int'(cur.rs)) && (m_ex_rd[d] != 0);
                mb = cur.valid && cur.rt_used && (m_ex_v[d] != 0) && (m_ex_we[d] != 0)
                     && (m_ex_rd[d] == int'(cur.rt)) && (m_ex_rd[d] != 0);
                if (cur.fl)         est = 1'b0;
                else if (m_rem[d] > 0) est = 1'b1;
                else                est = (ma || mb) && (m_ex_ld[d] != 0);
                esa = ma && (m_ex_ld[d] == 0) && !est && !cur.fl;
                esb = mb && (m_ex_ld[d] == 0) && !est && !cur.fl;
                a_sa  = (d == 0) ? 32'(bus1.sel_a) : 32'(bus3.sel_a);
                a_sb  = (d == 0) ? 32'(bus1.sel_b) : 32'(bus3.sel_b);
                a_st  = (d == 0) ? 32'(bus1.stall) : 32'(bus3.stall);
                a_cnt = (d == 0) ? 32'(bus1.stall_count) : 32'(bus3.stall_count);
                chk($sformatf("rnd%0d_d%0d_sel_a", c, d), a_sa, 32'(esa));
                chk($sformatf("rnd%0d_d%0d_sel_b", c, d), a_sb, 32'(esb));
                chk($sformatf("rnd%0d_d%0d_stall", c, d), a_st, 32'(est));
                chk($sformatf("rnd%0d_d%0d_cnt", c, d), a_cnt, 32'(m_cnt[d]));
                if (cur.fl)           m_rem[d] = 0;
                else if (m_rem[d] > 0) m_rem[d] = m_rem[d] - 1;
                else if (est)         m_rem[d] = LL[d] - 1;
                if (est || cur.fl) begin
                    m_ex_v[d] = 0; m_ex_rd[d] = 0; m_ex_we[d] = 0; m_ex_ld[d] = 0;
                end else begin
                    m_ex_v[d] = int'(cur.valid); m_ex_rd[d] = int'(cur.rd);
                    m_ex_we[d] = int'(cur.we);   m_ex_ld[d] = int'(cur.ld);
                end
                if (est && (m_cnt[d] < CMAX[d])) m_cnt[d] = m_cnt[d] + 1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Decode-stage hazard and forwarding controller for the 16-bit pipelined CPU.
- Tracks the destination of the instruction in EX and produces per-operand early selects (sel_a, sel_b). These drive the delayedS inputs of the operand delayed 2:1 muxes, which register them on the next CLK edge.
- Detects load-use hazards and holds decode with a counted stall.
- Counts stall cycles for performance debug.

Parameters:
- REG_AW, 4: register address width (16 architectural registers; r0 reads as zero, never forwarded).
- LOAD_LAT, 1: number of bubbles inserted per load-use hazard (legal range 1..3).
- CNT_W, 16: stall counter width.

Ports:
- CLK, input, 1: sole clock, rising edge.
- RESET_N, input, 1: asynchronous active-low reset.
- id_valid, input, 1: decode holds a valid instruction.
- id_rs, input, REG_AW: source A register.
- id_rs_used, input, 1: source A is read.
- id_rt, input, REG_AW: source B register.
- id_rt_used, input, 1: source B is read.
- id_rd, input, REG_AW: destination register.
- id_rd_we, input, 1: instruction writes id_rd.
- id_is_load, input, 1: instruction is a memory load.
- flush, input, 1: taken branch; kills the decode instruction this cycle.
- sel_a, output, 1: delayedS for the operand-A mux; 1 selects the EX/MEM ALU result.
- sel_b, output, 1: delayedS for the operand-B mux.
- stall, output, 1: hold PC and IF/ID this cycle; EX receives a bubble.
- stall_count, output, CNT_W: saturating count of stall cycles.

Behaviour:
- Reset (async, RESET_N low): ex_valid=0, ex_we=0, ex_load=0, ex_rd=0, state=RUN, bub_cnt=0, stall_count=0. All outputs read 0 while reset is held.
- EX tracking registers: ex_valid, ex_rd, ex_we, ex_load.
  - On each CLK edge, if stall=0 and flush=0, load them from id_valid, id_rd, id_rd_we and id_is_load.
  - Otherwise load a bubble (ex_valid=0).
- match_a (combinational) = id_valid & id_rs_used & ex_valid & ex_we & (ex_rd==id_rs) & (ex_rd!=0). match_b is the same using id_rt and id_rt_used.
- hazard = (match_a | match_b) & ex_load.
- Selects are combinational, with zero cycles of latency inside this block; the downstream mux adds one register stage.
  - sel_a = match_a & ~ex_load & ~stall & ~flush.
  - sel_b is the same using match_b.
- State machine:
  - RUN:
    - stall = hazard & ~flush.
    - If stall=1 and LOAD_LAT>1: go to STALL and set bub_cnt=LOAD_LAT-2.
    - Otherwise remain in RUN.
  - STALL:
    - stall = ~flush.
    - If bub_cnt==0: go to RUN.
    - Otherwise decrement bub_cnt.
  - flush in any state: go to RUN next edge, bub_cnt=0, stall=0 this cycle.
- After the final bubble the load has left EX; no match occurs and the operand comes from the register file path (sel=0).
- stall_count increments on every edge where stall=1 and saturates at all-ones; no wrap.
- Simultaneous events:
  - flush has priority over hazard and stall.
  - match_a and match_b may both be 1 in the same cycle (rs==rt==ex_rd), and both sels then assert.
- ex_rd==0 never matches, regardless of ex_we.

Decomposition:
- Shared CPU package holds:
  - REG_AW and the register-zero constant.
  - The state enum {RUN, STALL}.
  - The pipeline-tag struct {valid, rd, we, load} reused by later MEM/WB tracking.
- One natural sub-module: hazard_match_cmp, combinational. It compares one source against the EX tag and is instantiated twice, for rs and rt.

Test Plan:
- Reset mid-stall: RESET_N low during STALL -> all outputs 0 immediately; after release, state=RUN and stall_count=0.
- ALU back-to-back: cycle 0 decodes add r3 (we=1, load=0); cycle 1 decodes sub with rs=r3, rt=r5 -> sel_a=1, sel_b=0, stall=0 in cycle 1.
- Load-use, LOAD_LAT=1: cycle 0 decodes a load to r4; cycle 1 decodes an instruction with rt=r4 -> stall=1 for exactly 1 cycle, sel_b=0 throughout, stall_count=1.
- Load-use, LOAD_LAT=3: same stimulus as the LOAD_LAT=1 case -> stall=1 for 3 consecutive cycles, then 0; stall_count=3.
  - flush asserted in the second stall cycle instead -> stall drops that cycle and stall_count=1.
- r0 and double match:
  - Producer writes r0 and the consumer reads r0 -> sel_a=sel_b=0.
  - Producer writes r7 and the consumer has rs=rt=r7 -> sel_a=sel_b=1.
- Saturation: with CNT_W=4, drive 20 stall cycles -> stall_count holds at 15.
